bf16_fp8_drain: RTL and testbench
=================================

Name: bf16_fp8_drain

Overview:
- Read-out end of the systolic datapath. PEs take FP8 E4M3 operands and hold BF16 accumulators; this block is the conversion in the other direction.
- It accepts one row of N BF16 accumulator results in parallel and applies an optional power-of-two rescale.
- Each lane is requantized to FP8 E4M3 with round-to-nearest-even (RNE) and saturation.
- Lanes stream out serially, lane 0 first, over a valid/ready handshake, so results can feed the next layer's FP8 operand path.

Parameters:
- N, 4, number of BF16 lanes per row (matches array dimension).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  row present on load_data.
- load_ready  output  1  block can accept a row.
- load_data  input  16*N  BF16 lanes; lane i in bits [16i+15:16i].
- scale_exp  input  6  signed two's-complement exponent offset, sampled with load.
- out_valid  output  1  out_data holds a converted lane.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  8  FP8 E4M3 result.
- out_last  output  1  out_data is lane N-1 of the row.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; lane index=0. Outputs: out_valid=0, out_data=0x00, out_last=0, load_ready=1 (combinational from IDLE), busy=0. Assertion mid-row discards the row immediately.
- FSM states: IDLE, SEND, FLUSH.
  - IDLE: load_ready=1. On load_valid, capture all N lanes plus scale_exp into a buffer; idx=0; go to SEND.
  - SEND: when !out_valid || out_ready: out_data<=conv(buf[idx]), out_valid<=1, out_last<=(idx==N-1). If idx==N-1 go to FLUSH, else idx++. Otherwise hold.
  - FLUSH: on out_valid && out_ready: out_valid<=0, out_last<=0, go to IDLE.
- Handshake rules:
  - Transfer occurs on an edge where valid && ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on reset.
  - load_ready=0 in SEND and FLUSH.
- Timing with out_ready held high and load accepted at edge k:
  - lane i is valid after edge k+1+i and transferred at edge k+2+i;
  - IDLE is re-entered at edge k+N+1;
  - the next load is possible at edge k+N+2, so throughput is N outputs per N+2 cycles.
- conv(x), combinational between buffer and output register:
  - s=x[15], E=x[14:7], M=x[6:0].
  - If E==0: result 0x00. BF16 subnormals and ±0 both give +0.
  - If E==255 and M!=0 (NaN): result 0x7F.
  - If E==255 and M==0 (Inf): saturate to {s,0x7E}.
  - Otherwise e = E - 120 + scale_exp, computed signed and at least 10 bits wide.
  - If e<=0 (pre-round): flush to 0x00. There are no FP8 subnormals; FP8 exp field 0 means zero, matching PE decode.
  - Rounding on a 3-bit mantissa: m=M[6:4], guard=M[3], sticky=|M[2:0]; round up iff guard && (sticky || m[0]).
  - Mantissa carry-out: m=0, e=e+1.
  - After rounding, if e>15, or e==15 with m==7: saturate to {s,0x7E} (±448).
  - Otherwise result = {s, e[3:0], m}.
- Simultaneous events: load_valid outside IDLE is ignored and not captured; scale_exp is sampled only on the load transfer.

Test Plan:
- Basic values, N=4, scale_exp=0, out_ready=1: load {0x3F80,0x4000,0xBF80,0x0000} -> out_data 0x38,0x40,0xB8,0x00 on consecutive cycles; out_last only on 0x00; first out_valid one cycle after the load edge; load_ready high again after the final transfer.
- RNE: lane 0x3F88 -> 0x38 (tie, even); 0x3F98 -> 0x3A (tie, odd, round up); 0x3F89 -> 0x39 (sticky).
- Saturation and specials:
  - 0x43E0 -> 0x7E; 0x43F0 -> 0x7E; 0x4400 -> 0x7E; 0xC400 -> 0xFE;
  - 0x7F80 -> 0x7E; 0xFF80 -> 0xFE; 0x7FC0 -> 0x7F.
- Underflow: 0x3C00 -> 0x00; 0x3C80 -> 0x08; 0x8000 -> 0x00; 0x0001 -> 0x00.
- Scale and backpressure:
  - scale_exp=-2, lane 0x4080 -> 0x38;
  - with out_ready toggled pseudo-randomly, out_data/out_last are held stable while stalled, order is unchanged, and exactly N transfers occur;
  - load_valid held high mid-row is not captured.
- Reset: deassert rst_n after the second output transfer -> out_valid=0, out_data=0x00, load_ready=1 asynchronously; the next loaded row converts correctly starting from lane 0.

Source files
------------

// File: rtl/bf16_fp8_drain.sv
// bf16_fp8_drain
// Read-out end of the systolic datapath. Captures one row of N BF16
// accumulator results, applies a power-of-two rescale, requantizes each
// lane to FP8 E4M3 (round-to-nearest-even, saturating to +/-448) and
// streams the lanes out serially, lane 0 first, over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load_valid row present on load_data
//   load_ready block can accept a row (high only in IDLE)
//   load_data  N BF16 lanes, lane i in bits [16i+15:16i]
//   scale_exp  signed exponent offset, sampled with the row
//   out_valid  out_data holds a converted lane
//   out_ready  consumer accepts out_data
//   out_data   FP8 E4M3 result
//   out_last   out_data is lane N-1 of the row
//   busy       FSM is not IDLE
module bf16_fp8_drain #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [16*N-1:0] load_data,
  input  logic [5:0]      scale_exp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            last_reg, last_next;
  logic            capture;

  logic [15:0]     lane_buf [N];
  logic [5:0]      scale_reg;
  logic [7:0]      conv_result;

  // BF16 -> FP8 E4M3 with optional 2^scale rescale.
  function automatic logic [7:0] conv(input logic [15:0] x, input logic [5:0] sc);
    logic              s;
    logic [7:0]        ex;
    logic [6:0]        mt;
    logic signed [9:0] e;
    logic [3:0]        msum;
    logic [2:0]        m;
    logic              rup;
    s  = x[15];
    ex = x[14:7];
    mt = x[6:0];
    // BF16 bias 127, E4M3 bias 7 -> rebias by 120; 10 bits cover every
    // reachable value including the most negative scale.
    e  = $signed({2'b00, ex}) - 10'sd120 + $signed({{4{sc[5]}}, sc});
    rup  = mt[3] & ((|mt[2:0]) | mt[4]);
    msum = {1'b0, mt[6:4]} + {3'b000, rup};
    m    = msum[2:0];
    if (msum[3]) begin
      e = e + 10'sd1;
      m = 3'd0;
    end
    if (ex == 8'h00) begin
      conv = 8'h00;                          // zero and subnormals -> +0
    end else if (ex == 8'hFF) begin
      conv = (mt != 7'd0) ? 8'h7F : {s, 7'h7E};
    end else if (($signed({2'b00, ex}) - 10'sd120 + $signed({{4{sc[5]}}, sc})) <= 10'sd0) begin
      conv = 8'h00;                          // no FP8 subnormals; decided before rounding
    end else if ((e > 10'sd15) || ((e == 10'sd15) && (m == 3'd7))) begin
      conv = {s, 7'h7E};                     // 0x7F/0xFF are NaN encodings, clamp to 448
    end else begin
      conv = {s, e[3:0], m};
    end
  endfunction

  assign conv_result = conv(lane_buf[idx_reg], scale_reg);

  // Row buffer: plain data storage, written only on a load transfer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (capture) lane_buf[gi] <= load_data[16*gi +: 16];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (capture) scale_reg <= scale_exp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        // Output register is free when empty or being drained this edge.
        if (!valid_reg || out_ready) begin
          data_next  = conv_result;
          valid_next = 1'b1;
          last_next  = (idx_reg == IDX_LAST);
          if (idx_reg == IDX_LAST) state_next = FLUSH;
          else                     idx_next   = idx_reg + IW'(1);
        end
      end
      FLUSH: begin
        if (valid_reg && out_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = valid_reg;
  assign out_data   = data_reg;
  assign out_last   = last_reg;

endmodule

// File: tb/tb_bf16_fp8_drain.sv
// Directed testbench for bf16_fp8_drain (N=4).
module tb_bf16_fp8_drain;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic            load_valid;
  logic            load_ready;
  logic [16*N-1:0] load_data;
  logic [5:0]      scale_exp;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            out_last;
  logic            busy;

  int errors = 0;
  int checks = 0;

  int         n;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       done;
  logic [31:0] pat;
  logic [7:0] bp_exp [4];

  bf16_fp8_drain #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .scale_exp  (scale_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Present a row for exactly one edge; returns 1ns after the load edge.
  task automatic load_row(input logic [15:0] l0, input logic [15:0] l1,
                          input logic [15:0] l2, input logic [15:0] l3,
                          input logic [5:0] sc);
    @(negedge clk);
    load_data  = {l3, l2, l1, l0};
    scale_exp  = sc;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Cycle-exact check of a row drained with out_ready held high.
  task automatic send_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    ex = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk1($sformatf("%s latency_valid", tag), out_valid, 1'b0);
        chk1($sformatf("%s load_ready_low", tag), load_ready, 1'b0);
        chk1($sformatf("%s busy_high", tag), busy, 1'b1);
      end else if (i <= N) begin
        chk1($sformatf("%s lane%0d valid", tag, i - 1), out_valid, 1'b1);
        chk8($sformatf("%s lane%0d data", tag, i - 1), out_data, ex[i-1]);
        chk1($sformatf("%s lane%0d last", tag, i - 1), out_last, (i == N));
      end else begin
        chk1($sformatf("%s end_valid", tag), out_valid, 1'b0);
        chk1($sformatf("%s end_load_ready", tag), load_ready, 1'b1);
        chk1($sformatf("%s end_busy", tag), busy, 1'b0);
      end
    end
    $display("row %s done: checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    scale_exp  = 6'd0;
    out_ready  = 1'b0;
    #12;
    chk1("reset out_valid", out_valid, 1'b0);
    chk8("reset out_data", out_data, 8'h00);
    chk1("reset out_last", out_last, 1'b0);
    chk1("reset load_ready", load_ready, 1'b1);
    chk1("reset busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic values
    load_row(16'h3F80, 16'h4000, 16'hBF80, 16'h0000, 6'd0);
    send_check("basic", 8'h38, 8'h40, 8'hB8, 8'h00);

    // Round to nearest even, including mantissa carry-out
    load_row(16'h3F88, 16'h3F98, 16'h3F89, 16'h3FF8, 6'd0);
    send_check("rne", 8'h38, 8'h3A, 8'h39, 8'h40);

    // Saturation
    load_row(16'h43E0, 16'h43F0, 16'h4400, 16'hC400, 6'd0);
    send_check("sat", 8'h7E, 8'h7E, 8'h7E, 8'hFE);

    // Inf / NaN / exponent-zero boundary
    load_row(16'h7F80, 16'hFF80, 16'h7FC0, 16'h3C00, 6'd0);
    send_check("special", 8'h7E, 8'hFE, 8'h7F, 8'h00);

    // Underflow edge, negative zero, subnormal, round-up to 448
    load_row(16'h3C80, 16'h8000, 16'h0001, 16'h43D8, 6'd0);
    send_check("underflow", 8'h08, 8'h00, 8'h00, 8'h7E);

    // Rescale by 2^-2
    load_row(16'h4080, 16'h3F80, 16'h3C80, 16'h4400, 6'b111110);
    send_check("scale", 8'h38, 8'h28, 8'h00, 8'h70);

    // Backpressure with a spurious row held on load_valid mid-row
    bp_exp = '{8'h38, 8'h40, 8'hB8, 8'h00};
    pat    = 32'hB2716A5D;
    out_ready = 1'b0;
    load_row(16'h3F80, 16'h4000, 16'hBF80, 16'h0000, 6'd0);
    load_data  = {4{16'h4400}};
    scale_exp  = 6'd5;
    load_valid = 1'b1;
    n          = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    done       = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk1("bp hold valid", out_valid, 1'b1);
        chk8("bp hold data", out_data, prev_data);
        chk1("bp hold last", out_last, prev_last);
      end
      out_ready = pat[c % 32];
      if (out_valid && out_ready) begin
        chk8($sformatf("bp lane%0d data", n), out_data, bp_exp[n]);
        chk1($sformatf("bp lane%0d last", n), out_last, (n == N - 1));
        n++;
        if (n == N) begin
          load_valid = 1'b0;
          done       = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    checks++;
    assert (n == N) else begin
      errors++;
      $error("FAIL bp transfer_count: observed=%0d expected=%0d", n, N);
    end
    @(negedge clk);
    chk1("bp end valid", out_valid, 1'b0);
    chk1("bp end load_ready", load_ready, 1'b1);
    @(negedge clk);
    chk1("bp no_capture valid", out_valid, 1'b0);
    chk1("bp no_capture busy", busy, 1'b0);
    $display("row backpressure done: checks=%0d errors=%0d", checks, errors);

    // Reset mid-row after the second transfer
    load_row(16'h3F88, 16'h3F98, 16'h3F89, 16'h3FF8, 6'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk1("rst_row lane0 pending", out_valid, 1'b0);
    @(negedge clk);
    chk8("rst_row lane0 data", out_data, 8'h38);
    @(negedge clk);
    chk8("rst_row lane1 data", out_data, 8'h3A);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst out_valid", out_valid, 1'b0);
    chk8("async_rst out_data", out_data, 8'h00);
    chk1("async_rst out_last", out_last, 1'b0);
    chk1("async_rst load_ready", load_ready, 1'b1);
    chk1("async_rst busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    load_row(16'h43E0, 16'h43F0, 16'h4400, 16'hC400, 6'd0);
    send_check("after_reset", 8'h7E, 8'h7E, 8'h7E, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
